fetch_buffer: RTL

Instruction-fetch front end that drives the instruction memory and feeds the ID stage through the FD pipeline register.
- Owns the fetch PC and a small prefetch FIFO, so that ID stalls do not lose or duplicate instructions.
- Branch/jump redirects flush all queued and in-flight fetches.
- Presents NOP (add $0,$0,$0) to ID whenever no valid instruction is available.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_buffer.sv | 106 ++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch front end: address width, the NOP word
// presented to ID when nothing is valid, and the fetch FSM states.
package cpu_pkg;

    localparam int PC_W = 32;

    // add $0,$0,$0
    localparam logic [31:0] NOP_INSTR = 32'h0000_0020;

    typedef enum logic {
        IDLE,
        RUN
    } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO holding {instruction, address} pairs between imem and ID.
// Flush empties it outright and beats any push or pop in the same cycle.
module fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       push_data,
    output logic [WIDTH-1:0]       head,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    typedef logic [AW-1:0] ptr_t;
    typedef logic [AW:0]   cnt_t;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    ptr_t             rd_ptr_q, rd_ptr_d;
    ptr_t             wr_ptr_q, wr_ptr_d;
    cnt_t             count_q, count_d;

    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + ptr_t'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + ptr_t'(1);
            end
            if (push && !pop) begin
                count_d = count_q + cnt_t'(1);
            end else if (pop && !push) begin
                count_d = count_q - cnt_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '{default: '0};
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/fetch_buffer.sv
// Instruction-fetch front end: owns the fetch PC, issues one imem request per
// cycle while the prefetch FIFO has room, and feeds ID from the FIFO head.
module fetch_buffer #(
    parameter int               DEPTH    = 4,
    parameter int               PC_W     = cpu_pkg::PC_W,
    parameter logic [PC_W-1:0]  RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect_valid,
    input  logic [PC_W-1:0] redirect_pc,
    input  logic            id_ready,
    output logic            fd_valid,
    output logic [31:0]     fd_instr,
    output logic [PC_W-1:0] fd_pc
);

    import cpu_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int EW = 32 + PC_W;

    typedef logic [AW+1:0] occ_t;

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] req_pc_q, req_pc_d;
    logic            inflight_q, inflight_d;
    logic [AW:0]     fifo_count;
    logic [EW-1:0]   fifo_head;
    logic            fifo_push;
    logic            fifo_pop;
    occ_t            occupancy;

    // A request is only allowed if its response is guaranteed a FIFO slot,
    // so the in-flight word is counted as already occupying one.
    always_comb begin
        fd_valid  = (fifo_count != '0);
        fifo_pop  = fd_valid & id_ready & ~redirect_valid;
        fifo_push = inflight_q & ~redirect_valid;
        occupancy = occ_t'(fifo_count) + occ_t'(inflight_q) - occ_t'(fifo_pop);
        imem_req  = (state_q == RUN) && !redirect_valid && (occupancy < occ_t'(DEPTH));
    end

    // Clearing inflight on a redirect squashes the outstanding response, so a
    // stale word arriving the following cycle is simply never pushed.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = inflight_q;
        case (state_q)
            IDLE: state_d = RUN;
            RUN:  state_d = RUN;
        endcase
        if (redirect_valid) begin
            pc_d       = redirect_pc & ~PC_W'(3);
            inflight_d = 1'b0;
        end else begin
            if (fifo_push) begin
                inflight_d = 1'b0;
            end
            if (imem_req) begin
                pc_d       = pc_q + PC_W'(4);
                req_pc_d   = pc_q;
                inflight_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .pop       (fifo_pop),
        .flush     (redirect_valid),
        .push_data ({imem_rdata, req_pc_q}),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign imem_addr = pc_q;
    assign fd_instr  = fd_valid ? fifo_head[EW-1:PC_W] : NOP_INSTR;
    assign fd_pc     = fd_valid ? fifo_head[PC_W-1:0] + PC_W'(4) : '0;

endmodule
